// File: rtl/fp_add_seq.sv
// Sequential floating-point adder (flush-to-zero, round-to-nearest-even), one operation in flight.
// Result appears in DONE, the 5th cycle after the accepting edge, and is held there until out_ready.
module fp_add_seq #(
    parameter int EXPONENT_BITS = 8,
    parameter int FRACTION_BITS = 23,
    localparam int W = 1 + EXPONENT_BITS + FRACTION_BITS
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] sum,
    output logic         flag_zero,
    output logic         flag_inf,
    output logic         flag_nan,
    output logic         flag_ovf,
    output logic         flag_unf,
    output logic         flag_inexact
);
    localparam int E   = EXPONENT_BITS;
    localparam int F   = FRACTION_BITS;
    localparam int SW  = F + 4;
    localparam int EXW = 16;
    localparam logic [E-1:0] EXP_ONES = {E{1'b1}};
    localparam logic signed [EXW-1:0] EXP_MAX = EXW'((1 << E) - 1);
    localparam int FZ = 5, FI = 4, FN = 3, FO = 2, FU = 1, FX = 0;

    typedef enum logic [2:0] {IDLE, ALIGN, ADD, NORM, ROUND, DONE} state_e;

    state_e state_q, state_d;

    logic [W-1:0]            a_q, b_q;
    logic                    al_sign_q, al_sub_q;
    logic [E-1:0]            al_exp_q;
    logic [SW-1:0]           al_big_q, al_small_q;
    logic                    sp_vld_q;
    logic [W-1:0]            sp_sum_q;
    logic [5:0]              sp_flags_q;
    logic [SW:0]             ad_sum_q;
    logic [SW-1:0]           nm_sig_q;
    logic signed [EXW-1:0]   nm_exp_q;
    logic                    nm_zero_q;
    logic [W-1:0]            sum_q;
    logic [5:0]              flags_q;

    // ---------------- FSM ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid) state_d = ALIGN;
            ALIGN:   state_d = ADD;
            ADD:     state_d = NORM;
            NORM:    state_d = ROUND;
            ROUND:   state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign in_ready  = rst_n && (state_q == IDLE);
    assign out_valid = (state_q == DONE);

    // ---------------- ALIGN: classify, swap, align ----------------
    logic                    sa, sb;
    logic [E-1:0]            ea, eb, e_big, e_small;
    logic [F-1:0]            fa, fb, f_big, f_small;
    logic                    nan_a, nan_b, inf_a, inf_b, zero_a, zero_b, swap;
    logic [W-2:0]            mag_a, mag_b;
    logic [SW-1:0]           sig_big, sig_small, sig_shift, sig_lost, sig_aligned;
    logic [31:0]             exp_diff;
    logic                    sp_vld_d;
    logic [W-1:0]            sp_sum_d;
    logic [5:0]              sp_flags_d;

    assign {sa, ea, fa} = a_q;
    assign {sb, eb, fb} = b_q;
    assign nan_a  = (ea == EXP_ONES) && (fa != '0);
    assign nan_b  = (eb == EXP_ONES) && (fb != '0);
    assign inf_a  = (ea == EXP_ONES) && (fa == '0);
    assign inf_b  = (eb == EXP_ONES) && (fb == '0);
    assign zero_a = (ea == '0);
    assign zero_b = (eb == '0);

    // Denormals collapse to a zero magnitude, so they carry no hidden bit below.
    assign mag_a = zero_a ? '0 : {ea, fa};
    assign mag_b = zero_b ? '0 : {eb, fb};
    assign swap  = mag_b > mag_a;
    assign {e_big, f_big}     = swap ? mag_b : mag_a;
    assign {e_small, f_small} = swap ? mag_a : mag_b;

    assign sig_big   = {e_big != '0, f_big, 3'b000};
    assign sig_small = {e_small != '0, f_small, 3'b000};
    assign exp_diff  = 32'(e_big) - 32'(e_small);
    assign sig_shift = sig_small >> exp_diff;
    assign sig_lost  = sig_small & ~({SW{1'b1}} << exp_diff);

    always_comb begin
        if (exp_diff >= 32'(F + 3)) sig_aligned = {{(SW-1){1'b0}}, |sig_small};
        else                        sig_aligned = sig_shift | {{(SW-1){1'b0}}, |sig_lost};
    end

    always_comb begin
        sp_vld_d   = 1'b0;
        sp_sum_d   = '0;
        sp_flags_d = '0;
        if (nan_a || nan_b || (inf_a && inf_b && (sa != sb))) begin
            sp_vld_d       = 1'b1;
            sp_sum_d       = {1'b0, EXP_ONES, 1'b1, {(F-1){1'b0}}};
            sp_flags_d[FN] = 1'b1;
        end else if (inf_a || inf_b) begin
            sp_vld_d       = 1'b1;
            sp_sum_d       = {inf_a ? sa : sb, EXP_ONES, {F{1'b0}}};
            sp_flags_d[FI] = 1'b1;
        end else if (zero_a && zero_b) begin
            sp_vld_d       = 1'b1;
            sp_sum_d       = {sa & sb, {(W-1){1'b0}}};
            sp_flags_d[FZ] = 1'b1;
        end
    end

    // ---------------- ADD ----------------
    logic [SW:0] ad_sum_d;
    assign ad_sum_d = al_sub_q ? ({1'b0, al_big_q} - {1'b0, al_small_q})
                               : ({1'b0, al_big_q} + {1'b0, al_small_q});

    // ---------------- NORM ----------------
    logic [7:0]            lzc;
    logic [EXW-1:0]        exp_ext;
    logic [SW-1:0]         nm_sig_d;
    logic signed [EXW-1:0] nm_exp_d;
    logic                  nm_zero_d;

    always_comb begin
        lzc = '0;
        for (int i = 0; i < SW; i++) begin
            if (ad_sum_q[i]) lzc = 8'(SW - 1 - i);
        end
        nm_zero_d = (ad_sum_q == '0);
        exp_ext   = {{(EXW-E){1'b0}}, al_exp_q};
        if (ad_sum_q[SW]) begin
            nm_sig_d = {ad_sum_q[SW:2], ad_sum_q[1] | ad_sum_q[0]};
            nm_exp_d = exp_ext + 16'd1;
        end else begin
            nm_sig_d = ad_sum_q[SW-1:0] << lzc;
            nm_exp_d = exp_ext - {{(EXW-8){1'b0}}, lzc};
        end
    end

    // ---------------- ROUND and final packing ----------------
    logic                  grs_any, rnd_up;
    logic [F+1:0]          mant;
    logic [F-1:0]          rd_frac;
    logic signed [EXW-1:0] rd_exp;
    logic [W-1:0]          res_sum_d;
    logic [5:0]            res_flags_d;

    always_comb begin
        grs_any     = |nm_sig_q[2:0];
        rnd_up      = nm_sig_q[2] & (nm_sig_q[1] | nm_sig_q[0] | nm_sig_q[3]);
        mant        = {1'b0, nm_sig_q[SW-1:3]} + {{(F+1){1'b0}}, rnd_up};
        rd_exp      = nm_exp_q + {{(EXW-1){1'b0}}, mant[F+1]};
        rd_frac     = mant[F+1] ? mant[F:1] : mant[F-1:0];
        res_sum_d   = '0;
        res_flags_d = '0;
        if (sp_vld_q) begin
            res_sum_d   = sp_sum_q;
            res_flags_d = sp_flags_q;
        end else if (nm_zero_q) begin
            // Exact cancellation of nonzero operands is always +0.
            res_flags_d[FZ] = 1'b1;
        end else if (rd_exp >= EXP_MAX) begin
            res_sum_d       = {al_sign_q, EXP_ONES, {F{1'b0}}};
            res_flags_d[FO] = 1'b1;
            res_flags_d[FI] = 1'b1;
            res_flags_d[FX] = grs_any;
        end else if (rd_exp[EXW-1] || (rd_exp == '0)) begin
            res_sum_d       = {al_sign_q, {(W-1){1'b0}}};
            res_flags_d[FZ] = 1'b1;
            res_flags_d[FU] = 1'b1;
            res_flags_d[FX] = grs_any;
        end else begin
            res_sum_d       = {al_sign_q, rd_exp[E-1:0], rd_frac};
            res_flags_d[FX] = grs_any;
        end
    end

    // Only one operation is in flight, so ALIGN-stage registers (sign, exponent,
    // special result) stay valid and are read directly by the later stages.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q        <= '0;
            b_q        <= '0;
            al_sign_q  <= 1'b0;
            al_sub_q   <= 1'b0;
            al_exp_q   <= '0;
            al_big_q   <= '0;
            al_small_q <= '0;
            sp_vld_q   <= 1'b0;
            sp_sum_q   <= '0;
            sp_flags_q <= '0;
            ad_sum_q   <= '0;
            nm_sig_q   <= '0;
            nm_exp_q   <= '0;
            nm_zero_q  <= 1'b0;
            sum_q      <= '0;
            flags_q    <= '0;
        end else begin
            if ((state_q == IDLE) && in_valid) begin
                a_q <= a;
                b_q <= b;
            end
            if (state_q == ALIGN) begin
                al_sign_q  <= swap ? sb : sa;
                al_sub_q   <= sa ^ sb;
                al_exp_q   <= e_big;
                al_big_q   <= sig_big;
                al_small_q <= sig_aligned;
                sp_vld_q   <= sp_vld_d;
                sp_sum_q   <= sp_sum_d;
                sp_flags_q <= sp_flags_d;
            end
            if (state_q == ADD) ad_sum_q <= ad_sum_d;
            if (state_q == NORM) begin
                nm_sig_q  <= nm_sig_d;
                nm_exp_q  <= nm_exp_d;
                nm_zero_q <= nm_zero_d;
            end
            if (state_q == ROUND) begin
                sum_q   <= res_sum_d;
                flags_q <= res_flags_d;
            end
        end
    end

    assign sum = sum_q;
    assign {flag_zero, flag_inf, flag_nan, flag_ovf, flag_unf, flag_inexact} = flags_q;

endmodule

// File: tb/tb_fp_add_seq.sv
// Directed bench for fp_add_seq (8/23): vector table plus stall, throughput and reset sequences.
module tb_fp_add_seq;
    localparam logic [5:0] F_NONE = 6'b000000;
    localparam logic [5:0] F_Z    = 6'b100000;
    localparam logic [5:0] F_I    = 6'b010000;
    localparam logic [5:0] F_N    = 6'b001000;
    localparam logic [5:0] F_O    = 6'b000100;
    localparam logic [5:0] F_U    = 6'b000010;
    localparam logic [5:0] F_X    = 6'b000001;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] s;
        logic [5:0]  f;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        in_ready, out_valid;
    logic [31:0] sum;
    logic        flag_zero, flag_inf, flag_nan, flag_ovf, flag_unf, flag_inexact;
    logic [5:0]  flags_o;

    always #5 clk = ~clk;

    fp_add_seq #(.EXPONENT_BITS(8), .FRACTION_BITS(23)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready), .sum(sum),
        .flag_zero(flag_zero), .flag_inf(flag_inf), .flag_nan(flag_nan),
        .flag_ovf(flag_ovf), .flag_unf(flag_unf), .flag_inexact(flag_inexact)
    );

    assign flags_o = {flag_zero, flag_inf, flag_nan, flag_ovf, flag_unf, flag_inexact};

    int          checks = 0;
    int          errors = 0;
    logic [31:0] got_sum;
    logic [5:0]  got_flags;
    int          got_lat;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Present operands, wait for accept, then count edges until out_valid.
    task automatic start_op(input logic [31:0] va, input logic [31:0] vb);
        int n;
        @(negedge clk);
        a = va;
        b = vb;
        in_valid = 1'b1;
        out_ready = 1'b0;
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("in_ready before accept", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        got_lat = n;
        @(negedge clk);
        got_sum   = sum;
        got_flags = flags_o;
    endtask

    task automatic finish_op();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("out_valid after handshake", 32'(out_valid), 32'd0);
        check("in_ready after handshake", 32'(in_ready), 32'd1);
    endtask

    initial begin
        vec_t vecs[21];
        int   first_acc, second_acc, overlap;
        bit   seen;

        vecs[0]  = '{32'h3F800000, 32'h40000000, 32'h40400000, F_NONE};
        vecs[1]  = '{32'h3F800000, 32'hBF800000, 32'h00000000, F_Z};
        vecs[2]  = '{32'h7F800000, 32'hFF800000, 32'h7FC00000, F_N};
        vecs[3]  = '{32'h7F7FFFFF, 32'h7F7FFFFF, 32'h7F800000, F_O | F_I};
        vecs[4]  = '{32'h3F800000, 32'h33800000, 32'h3F800000, F_X};
        vecs[5]  = '{32'h40400000, 32'hBF800000, 32'h40000000, F_NONE};
        vecs[6]  = '{32'h3F800000, 32'hC0000000, 32'hBF800000, F_NONE};
        vecs[7]  = '{32'h80000000, 32'h80000000, 32'h80000000, F_Z};
        vecs[8]  = '{32'h00000000, 32'h80000000, 32'h00000000, F_Z};
        vecs[9]  = '{32'hFFA00000, 32'h3F800000, 32'h7FC00000, F_N};
        vecs[10] = '{32'hFF800000, 32'h3F800000, 32'hFF800000, F_I};
        vecs[11] = '{32'h7F800000, 32'h7F800000, 32'h7F800000, F_I};
        vecs[12] = '{32'h00000001, 32'h3F800000, 32'h3F800000, F_NONE};
        vecs[13] = '{32'h80000001, 32'h80000002, 32'h80000000, F_Z};
        vecs[14] = '{32'h00800001, 32'h80800000, 32'h00000000, F_Z | F_U};
        vecs[15] = '{32'h3F800001, 32'h33800000, 32'h3F800002, F_X};
        vecs[16] = '{32'h3F800000, 32'h00800000, 32'h3F800000, F_X};
        vecs[17] = '{32'h3F800000, 32'hB3800000, 32'h3F7FFFFF, F_NONE};
        vecs[18] = '{32'h3FFFFFFF, 32'h33800000, 32'h40000000, F_X};
        vecs[19] = '{32'h7F7FFFFF, 32'h73000000, 32'h7F800000, F_O | F_I | F_X};
        vecs[20] = '{32'h40000000, 32'h3F800000, 32'h40400000, F_NONE};

        // Reset state while rst_n is held low
        #12;
        check("reset out_valid", 32'(out_valid), 32'd0);
        check("reset sum", sum, 32'h0);
        check("reset flags", 32'(flags_o), 32'h0);
        rst_n = 1'b1;
        @(negedge clk);
        check("in_ready after reset", 32'(in_ready), 32'd1);

        // Table vectors; DONE is reached on the 4th edge after accept (5th cycle)
        for (int i = 0; i < 21; i++) begin
            start_op(vecs[i].a, vecs[i].b);
            check($sformatf("vec%0d latency", i), 32'(got_lat), 32'd4);
            check($sformatf("vec%0d sum", i), got_sum, vecs[i].s);
            check($sformatf("vec%0d flags", i), 32'(got_flags), 32'(vecs[i].f));
            finish_op();
        end

        // Output held for 10 cycles with out_ready low
        start_op(32'h3F800000, 32'h40000000);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            check($sformatf("stall%0d sum", c), sum, 32'h40400000);
            check($sformatf("stall%0d flags", c), 32'(flags_o), 32'h0);
            check($sformatf("stall%0d out_valid", c), 32'(out_valid), 32'd1);
            check($sformatf("stall%0d in_ready", c), 32'(in_ready), 32'd0);
        end
        finish_op();

        // Back-to-back operations: one accept per 6 cycles, never accept during output
        @(negedge clk);
        a = 32'h3F800000;
        b = 32'h40000000;
        in_valid = 1'b1;
        out_ready = 1'b1;
        first_acc = -1;
        second_acc = -1;
        overlap = 0;
        for (int c = 0; c < 20; c++) begin
            if (in_ready) begin
                if (first_acc < 0) first_acc = c;
                else if (second_acc < 0) second_acc = c;
            end
            if (in_ready && out_valid) overlap++;
            @(negedge clk);
        end
        in_valid = 1'b0;
        check("throughput first accept", 32'(first_acc), 32'd0);
        check("throughput period", 32'(second_acc - first_acc), 32'd6);
        check("accept during output", 32'(overlap), 32'd0);
        repeat (10) @(negedge clk);
        out_ready = 1'b0;

        // Reset pulse while in ALIGN discards the operation
        @(negedge clk);
        a = 32'h3F800000;
        b = 32'h40000000;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        rst_n = 1'b0;
        #2;
        check("align reset out_valid", 32'(out_valid), 32'd0);
        rst_n = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        check("no out_valid after align reset", 32'(seen), 32'd0);
        check("in_ready after align reset", 32'(in_ready), 32'd1);

        // Asynchronous reset between edges while holding a result in DONE
        start_op(32'h3F800000, 32'h40000000);
        check("pre-reset sum", got_sum, 32'h40400000);
        #2;
        rst_n = 1'b0;
        #1;
        check("async reset sum", sum, 32'h0);
        check("async reset flags", 32'(flags_o), 32'h0);
        check("async reset out_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("in_ready after async reset", 32'(in_ready), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
